axi4_mem_slave: RTL and testbench
=================================

Name: axi4_mem_slave

Overview:
AXI4 memory-mapped slave that fronts an internal word-addressed memory array. Independent write (AW/W/B) and read (AR/R) channel state machines. Supports INCR bursts of 1–256 beats. Sits behind the shared bus interface, alongside the monitor and assertion checker that observe the same signals.

Parameters:
DATA_WIDTH, 32, data bus width in bits (fixed 4-byte beats)
ADDR_WIDTH, 16, byte address width
MEMORY_DEPTH, 1024, number of DATA_WIDTH words in the array

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  ADDR_WIDTH  write burst start byte address
AWLEN  in  8  write beats minus 1
AWSIZE  in  3  beat size; only 3'b010 supported
AWVALID / AWREADY  in / out  1  write address handshake
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes (used only with the optional feature)
WLAST  in  1  last write beat marker
WVALID / WREADY  in / out  1  write data handshake
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID / BREADY  out / in  1  write response handshake
ARADDR  in  ADDR_WIDTH  read burst start byte address
ARLEN  in  8  read beats minus 1
ARSIZE  in  3  beat size; only 3'b010 supported
ARVALID / ARREADY  in / out  1  read address handshake
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RLAST  out  1  last read beat
RVALID / RREADY  out / in  1  read data handshake

Behaviour:
- Reset (async, ARESETn=0): AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST=0; BRESP=RRESP=00; RDATA=0; both FSMs go to IDLE. Memory contents are not cleared.
- Reset mid-burst aborts the burst with no response; partial writes already committed stay in memory.
- Word index = byte address >> 2. Burst type is always treated as INCR. Each beat adds 4 to the address.
- Burst error condition: start index + LEN >= MEMORY_DEPTH, or (addr[11:0] + (LEN+1)*4) > 4096 (4KB crossing).
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, capture addr, len and error flag; next cycle AWREADY=0, WREADY=1.
  - W_DATA: on each WVALID&WREADY, write WDATA to mem[index] unless error; increment beat count. The beat with count==LEN ends the burst regardless of WLAST. WLAST on any other beat is ignored.
  - After the final beat: WREADY=0; next cycle BVALID=1, BRESP=10 if error else 00.
  - W_RESP: BVALID and BRESP held stable until BREADY. After the handshake: BVALID=0, AWREADY=1.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY: ARREADY=0. The cycle after the handshake: RVALID=1, RDATA=mem[index] (0 if error), RRESP=10/00, RLAST=(LEN==0).
  - R_DATA: RDATA, RRESP and RLAST held stable while RVALID&!RREADY. On each handshake, the next beat is presented the following cycle (full throughput under RREADY=1).
  - After the handshake with RLAST=1: RVALID=0, RLAST=0, ARREADY=1.
- Write and read channels operate concurrently (dual-port array). A read of a word in the same cycle it is written returns the old value.
- Unsupported AxSIZE values are treated as size 2.

Optional Feature:
Macro AXI4_WSTRB_EN.
- Defined: each write beat updates only byte lanes whose WSTRB bit is 1; other lanes keep prior contents.
- Undefined: WSTRB is ignored and full words are always written.

Test Plan:
- Reset: ARESETn low for 3 cycles -> AWREADY=1, ARREADY=1, BVALID=0, RVALID=0, WREADY=0.
- Single write then read: AWADDR=0x0010, AWLEN=0, WDATA=0xDEADBEEF, BREADY=1 -> BRESP=00. Then ARADDR=0x0010, ARLEN=0 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
- INCR burst: AWADDR=0x0100, AWLEN=3, data 1..4 -> BRESP=00. Read back ARLEN=3 -> RDATA 1,2,3,4 with RLAST only on beat 4.
- Backpressure: read burst of 4 with RREADY toggled 1/0 -> RDATA/RLAST stable while stalled; BVALID held 5 cycles until BREADY.
- Errors:
  - AWADDR=0x0FFC, AWLEN=1 (4KB crossing) -> BRESP=10, no memory change.
  - ARADDR=0x1000 (index 1024) -> RRESP=10, RDATA=0.
- Reset mid-burst: ARESETn pulsed during beat 2 of a 4-beat write -> no BVALID, AWREADY=1 after release.

Source files
------------

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write and read channel FSMs over a dual-port word array.
// Optional byte-lane write strobes are enabled by defining AXI4_WSTRB_EN.
module axi4_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic [1:0]            w_state_r;
    logic [IDX_W-1:0]      w_idx_r;
    logic [7:0]            w_len_r;
    logic [7:0]            w_cnt_r;
    logic                  w_err_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  w_fire_s;

    logic [0:0]            r_state_r;
    logic [IDX_W-1:0]      r_idx_r;
    logic [7:0]            r_len_r;
    logic [7:0]            r_cnt_r;
    logic                  r_err_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [1:0]            rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [IDX_W-1:0]      r_idx_nx_s;

    // Sizes other than 4 bytes are treated as 4-byte beats; WLAST never ends a burst early.
    logic unused_s;
    assign unused_s = ^{AWSIZE, ARSIZE, WLAST, WSTRB};

    // A burst is rejected if it runs off the end of the array or crosses a 4KB boundary.
    function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len);
        logic [31:0] start_idx;
        logic [31:0] end_off;
        start_idx = 32'(addr) >> 2;
        end_off   = {20'd0, addr[11:0]} + (({24'd0, len} + 32'd1) << 2);
        burst_err = ((start_idx + {24'd0, len}) >= 32'(MEMORY_DEPTH)) || (end_off > 32'd4096);
    endfunction

    // Qualify a write beat that must be committed to the array.
    always_comb begin
        w_fire_s = 1'b0;
        if ((w_state_r == W_DATA) && WVALID && wready_r && !w_err_r) begin
            w_fire_s = 1'b1;
        end else begin
            w_fire_s = 1'b0;
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (w_fire_s) begin
`ifdef AXI4_WSTRB_EN
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (WSTRB[b]) begin
                    mem[w_idx_r][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
`else
            mem[w_idx_r] <= WDATA;
`endif
        end
    end

    // Write channel FSM: address capture, beat counting and response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_r <= W_IDLE;
            w_idx_r   <= '0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_err_r   <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (AWVALID && awready_r) begin
                        w_idx_r   <= AWADDR[IDX_W+1:2];
                        w_len_r   <= AWLEN;
                        w_cnt_r   <= 8'd0;
                        w_err_r   <= burst_err(AWADDR, AWLEN);
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && wready_r) begin
                        if (w_cnt_r == w_len_r) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= w_err_r ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end else begin
                            w_cnt_r <= w_cnt_r + 8'd1;
                            w_idx_r <= w_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_r  <= 1'b0;
                        bresp_r   <= RESP_OKAY;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    bresp_r   <= RESP_OKAY;
                end
            endcase
        end
    end

    // Next sequential word index for the read burst.
    always_comb begin
        r_idx_nx_s = r_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end

    // Read channel FSM: registered read data, one beat per cycle while RREADY is high.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_r <= R_IDLE;
            r_idx_r   <= '0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_err_r   <= 1'b0;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ARVALID && arready_r) begin
                        r_idx_r   <= ARADDR[IDX_W+1:2];
                        r_len_r   <= ARLEN;
                        r_cnt_r   <= 8'd0;
                        r_err_r   <= burst_err(ARADDR, ARLEN);
                        arready_r <= 1'b0;
                        rvalid_r  <= 1'b1;
                        rlast_r   <= (ARLEN == 8'd0);
                        rresp_r   <= burst_err(ARADDR, ARLEN) ? RESP_SLVERR : RESP_OKAY;
                        rdata_r   <= burst_err(ARADDR, ARLEN) ? '0 : mem[ARADDR[IDX_W+1:2]];
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_r && RREADY) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            r_cnt_r <= r_cnt_r + 8'd1;
                            r_idx_r <= r_idx_nx_s;
                            rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
                            rdata_r <= r_err_r ? '0 : mem[r_idx_nx_s];
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BRESP   = bresp_r;
    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RLAST   = rlast_r;
    assign RRESP   = rresp_r;
    assign RDATA   = rdata_r;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed self-checking bench for axi4_mem_slave: reset, single/burst transfers, backpressure, errors, mid-burst reset.
module tb_axi4_mem_slave;

    logic        ACLK;
    logic        ARESETn;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int checks;
    int fails;
    logic [31:0] wdat [8];

    axi4_mem_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic sig(input int which);
        case (which)
            0:       sig = AWREADY;
            1:       sig = WREADY;
            2:       sig = BVALID;
            3:       sig = ARREADY;
            4:       sig = RVALID;
            default: sig = 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int n;
        n = 0;
        while (sig(which) !== 1'b1 && n < 100) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (sig(which) !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout, signal got %b required 1", tag, sig(which));
        end
    endtask

    task automatic cycle();
        @(posedge ACLK); #1;
    endtask

    task automatic do_aw(input logic [15:0] addr, input logic [7:0] len);
        AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        wait_for(0, "awready");
        cycle();
        AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic last);
        WDATA = data; WLAST = last; WVALID = 1'b1;
        wait_for(1, "wready");
        cycle();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic write_burst(input logic [15:0] addr, input logic [7:0] len);
        do_aw(addr, len);
        for (int i = 0; i <= int'(len); i++) do_w(wdat[i], i == int'(len));
    endtask

    task automatic do_ar(input logic [15:0] addr, input logic [7:0] len);
        ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        wait_for(3, "arready");
        cycle();
        ARVALID = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) cycle();
        checks++; if (AWREADY !== 1'b1) begin fails++; $display("FAIL rst_awready: got %b exp 1", AWREADY); end
        checks++; if (ARREADY !== 1'b1) begin fails++; $display("FAIL rst_arready: got %b exp 1", ARREADY); end
        checks++; if (WREADY !== 1'b0) begin fails++; $display("FAIL rst_wready: got %b exp 0", WREADY); end
        checks++; if (BVALID !== 1'b0) begin fails++; $display("FAIL rst_bvalid: got %b exp 0", BVALID); end
        checks++; if (RVALID !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got %b exp 0", RVALID); end
        checks++; if (RDATA !== 32'h0 || RLAST !== 1'b0) begin fails++; $display("FAIL rst_rdata: got %h/%b exp 0/0", RDATA, RLAST); end
        ARESETn = 1'b1;
        cycle();
        checks++; if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin fails++; $display("FAIL rst_release: got %b%b exp 11", AWREADY, ARREADY); end
    endtask

    task automatic test_single();
        BREADY = 1'b1; RREADY = 1'b1;
        wdat[0] = 32'hDEADBEEF;
        write_burst(16'h0010, 8'd0);
        wait_for(2, "single_bvalid");
        checks++; if (BRESP !== 2'b00) begin fails++; $display("FAIL single_bresp: got %b exp 00", BRESP); end
        cycle();
        checks++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin fails++; $display("FAIL single_bdone: got bvalid %b awready %b exp 0 1", BVALID, AWREADY); end
        do_ar(16'h0010, 8'd0);
        wait_for(4, "single_rvalid");
        checks++; if (RDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rdata: got %h exp deadbeef", RDATA); end
        checks++; if (RLAST !== 1'b1 || RRESP !== 2'b00) begin fails++; $display("FAIL single_rlast: got %b/%b exp 1/00", RLAST, RRESP); end
        cycle();
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin fails++; $display("FAIL single_rdone: got rvalid %b arready %b exp 0 1", RVALID, ARREADY); end
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] resp);
        do_ar(addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            wait_for(4, tag);
            checks++; if (RDATA !== wdat[i]) begin fails++; $display("FAIL %s_data%0d: got %h exp %h", tag, i, RDATA, wdat[i]); end
            checks++; if (RLAST !== (i == int'(len)) || RRESP !== resp) begin fails++; $display("FAIL %s_last%0d: got %b/%b exp %b/%b", tag, i, RLAST, RRESP, (i == int'(len)), resp); end
            cycle();
        end
        checks++; if (RVALID !== 1'b0) begin fails++; $display("FAIL %s_end: rvalid got %b exp 0", tag, RVALID); end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
        write_burst(16'h0100, 8'd3);
        wait_for(2, "burst_bvalid");
        checks++; if (BRESP !== 2'b00) begin fails++; $display("FAIL burst_bresp: got %b exp 00", BRESP); end
        cycle();
        read_check("burst_rd", 16'h0100, 8'd3, 2'b00);
    endtask

    task automatic test_wlast_ignored();
        wdat[0] = 32'hA5A5_0000; wdat[1] = 32'hA5A5_0001;
        do_aw(16'h0200, 8'd1);
        do_w(wdat[0], 1'b1);
        checks++; if (WREADY !== 1'b1 || BVALID !== 1'b0) begin fails++; $display("FAIL wlast_early: got wready %b bvalid %b exp 1 0", WREADY, BVALID); end
        do_w(wdat[1], 1'b0);
        wait_for(2, "wlast_bvalid");
        cycle();
        read_check("wlast_rd", 16'h0200, 8'd1, 2'b00);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic        held_last;
        for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
        RREADY = 1'b0;
        do_ar(16'h0100, 8'd3);
        for (int i = 0; i < 4; i++) begin
            wait_for(4, "bp_rvalid");
            held = RDATA; held_last = RLAST;
            cycle();
            checks++; if (RVALID !== 1'b1 || RDATA !== held || RLAST !== held_last) begin fails++; $display("FAIL bp_stall%0d: got %b %h %b exp 1 %h %b", i, RVALID, RDATA, RLAST, held, held_last); end
            checks++; if (RDATA !== wdat[i] || RLAST !== (i == 3)) begin fails++; $display("FAIL bp_data%0d: got %h/%b exp %h/%b", i, RDATA, RLAST, wdat[i], (i == 3)); end
            RREADY = 1'b1;
            cycle();
            RREADY = 1'b0;
        end
        checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin fails++; $display("FAIL bp_end: got rvalid %b arready %b exp 0 1", RVALID, ARREADY); end
        RREADY = 1'b1;
        BREADY = 1'b0;
        wdat[0] = 32'h0000_5555;
        write_burst(16'h0020, 8'd0);
        wait_for(2, "bp_bvalid");
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin fails++; $display("FAIL bp_bhold%0d: got %b/%b exp 1/00", i, BVALID, BRESP); end
        end
        BREADY = 1'b1;
        cycle();
        checks++; if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin fails++; $display("FAIL bp_bdone: got bvalid %b awready %b exp 0 1", BVALID, AWREADY); end
    endtask

    task automatic test_errors();
        wdat[0] = 32'h2222_2222; wdat[1] = 32'h1111_1111;
        write_burst(16'h0FF8, 8'd1);
        wait_for(2, "err_ok_bvalid");
        checks++; if (BRESP !== 2'b00) begin fails++; $display("FAIL err_edge_bresp: got %b exp 00", BRESP); end
        cycle();
        wdat[0] = 32'hBAD0_0000; wdat[1] = 32'hBAD0_0001;
        write_burst(16'h0FFC, 8'd1);
        wait_for(2, "err_bvalid");
        checks++; if (BRESP !== 2'b10) begin fails++; $display("FAIL err_4k_bresp: got %b exp 10", BRESP); end
        cycle();
        wdat[0] = 32'h2222_2222; wdat[1] = 32'h1111_1111;
        read_check("err_nochange", 16'h0FF8, 8'd1, 2'b00);
        wdat[0] = 32'h0;
        read_check("err_rd", 16'h1000, 8'd0, 2'b10);
    endtask

    task automatic test_reset_mid_burst();
        do_aw(16'h0300, 8'd3);
        do_w(32'hA0A0_A0A0, 1'b0);
        WDATA = 32'hA1A1_A1A1; WVALID = 1'b1;
        ARESETn = 1'b0;
        cycle();
        ARESETn = 1'b1; WVALID = 1'b0;
        checks++; if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin fails++; $display("FAIL midrst_ready: got aw %b w %b exp 1 0", AWREADY, WREADY); end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (BVALID !== 1'b0) begin fails++; $display("FAIL midrst_bvalid%0d: got %b exp 0", i, BVALID); end
        end
        wdat[0] = 32'hA0A0_A0A0;
        read_check("midrst_rd", 16'h0300, 8'd0, 2'b00);
    endtask

    initial begin
        checks = 0; fails = 0;
        ARESETn = 1'b0;
        AWADDR = 16'h0; AWLEN = 8'd0; AWSIZE = 3'b010; AWVALID = 1'b0;
        WDATA = 32'h0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = 16'h0; ARLEN = 8'd0; ARSIZE = 3'b010; ARVALID = 1'b0; RREADY = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_wlast_ignored();
        test_backpressure();
        test_errors();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
